serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes diff = A - B - borrow_in, one bit per clock, LSB first, using a single full-subtractor cell and shift registers.
- This is the subtract-direction, sequential counterpart to the team's combinational ripple-carry adder.
- Used where area matters more than latency; a start/busy/done handshake sits in front of the datapath.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- borrow_in  input  1  initial borrow; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result; held until the next accepted start.
- borrow_out  output  1  final borrow (1 when A < B + borrow_in, unsigned); held like diff.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately) forces the following, with no clock required:
  - state IDLE
  - busy=0, done=0, diff=0, borrow_out=0
  - internal shift registers, borrow flop and bit counter cleared
- A reset mid-operation abandons the operation; no done pulse is produced.
- States:
  - IDLE: busy=0. On an edge with start=1: capture A, B, borrow_in; clear counter; go to SHIFT.
  - SHIFT: busy=1. Each edge does the following:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~a0 & br) | (b0 & br)
    - shift d into the result MSB; shift the A/B registers right; counter increments
    - On the WIDTH-th SHIFT edge: go to DONE; diff and borrow_out take their final values; done=1; busy=0.
  - DONE: lasts exactly one cycle with done=1.
    - start=1 on the next edge: accept the new operands (same as IDLE); go to SHIFT; done falls.
    - Otherwise go to IDLE; done falls.
- Latency: start sampled at edge k gives done high from edge k+WIDTH to edge k+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands are not re-captured and the operation in flight is unaffected.
- Operand changes after the accepting edge have no effect.
- diff is modulo 2^WIDTH (wrap-around), e.g. 0-1 → all ones with borrow_out=1.
- diff/borrow_out keep their previous values during SHIFT; the intermediate shift register is internal. They update only on the edge that enters DONE.
- The counter is sized $clog2(WIDTH+1) bits and never wraps in normal operation.

Optional Feature:
- Macro SERSUB_OVERFLOW_EN.
- When defined: adds output port overflow (1 bit), the two's-complement signed overflow of A - B - borrow_in.
  - overflow = (A[WIDTH-1] != B[WIDTH-1]) & (diff[WIDTH-1] != A[WIDTH-1]), evaluated on the captured operands.
  - Registered; updates on the same edge as diff; reset 0; held with diff.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic: WIDTH=4, A=5, B=3, borrow_in=0, start 1 cycle.
  - → busy=1 for 4 cycles, then done=1 for exactly 1 cycle; diff=4'b0010, borrow_out=0.
- Wrap: A=1, B=2, borrow_in=0 → diff=4'b1111, borrow_out=1.
- Borrow chain: A=10, B=5, borrow_in=1 → diff=4'b0100, borrow_out=0.
- Edge: A=0, B=0, borrow_in=1 → diff=4'b1111, borrow_out=1.
- Back-to-back and busy handling:
  - start held high through an operation, with A/B changed while busy → first result uses the original operands.
  - Second op accepted on the done edge; its done arrives exactly 5 cycles after the first.
- Reset and overflow:
  - rst_n pulsed low during the 2nd SHIFT cycle → busy, done, diff, borrow_out all 0 immediately; no done pulse follows.
  - With SERSUB_OVERFLOW_EN: A=4'b0111, B=4'b1000 → diff=4'b1111, overflow=1.
  - With SERSUB_OVERFLOW_EN: A=5, B=3 → overflow=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor. It computes diff = A - B - borrow_in one bit per
// clock, LSB first. One full-subtractor cell feeds a result shift register. A start/busy/done
// handshake sits in front of the datapath.
//
// Optional feature (compile-time macro SERSUB_OVERFLOW_EN): adds a registered 'overflow'
// output. This output is the two's-complement signed overflow of A - B - borrow_in.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request; sampled only when not busy
//   A           in   [WIDTH-1:0] minuend, captured on the accepting edge
//   B           in   [WIDTH-1:0] subtrahend, captured on the accepting edge
//   borrow_in   in   initial borrow, captured on the accepting edge
//   busy        out  high while bits are being processed
//   done        out  one-cycle pulse; result valid
//   diff        out  [WIDTH-1:0] result, held until the next accepted start
//   borrow_out  out  final borrow (1 when A < B + borrow_in, unsigned)
//   overflow    out  signed overflow (only with SERSUB_OVERFLOW_EN)

module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERSUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 bits already produced. The last bit goes straight into diff.
    logic [WIDTH-2:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;

`ifdef SERSUB_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    logic             a0;
    logic             b0;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             accept;
    logic             last_bit;

    always_comb begin
        a0       = a_sr[0];
        b0       = b_sr[0];
        d        = a0 ^ b0 ^ br;
        br_next  = (~a0 & b0) | (~a0 & br) | (b0 & br);
        res_next = {d, res_sr};
        // A new operation is accepted from IDLE or DONE. start is ignored while shifting.
        accept   = start && ((state == StIdle) || (state == StDone));
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else if (accept) begin
            a_sr   <= A;
            b_sr   <= B;
            br     <= borrow_in;
            res_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
            state  <= StShift;
`ifdef SERSUB_OVERFLOW_EN
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
`endif
        end else begin
            unique case (state)
                StShift: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    res_sr <= res_next[WIDTH-1:1];
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        diff       <= res_next;
                        borrow_out <= br_next;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= StDone;
`ifdef SERSUB_OVERFLOW_EN
                        // d is the result MSB on the final bit.
                        overflow   <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
